// File: rtl/seletor_notas.sv
// Note key input stage: synchronises, debounces and prioritises the seven note keys and the sharp key.
// It holds the selected note after release so the downstream seven-segment decoder always sees a stable code.
module seletor_notas #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] TECLAS,
    input  logic       SUSTENIDO,
    output logic [2:0] NOTAS,
    output logic       TOM,
    output logic       NOTA_VALIDA,
    output logic       NOVA_NOTA
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned HOLD_W = 16;
    localparam logic [CNT_W-1:0]  CNT_TERM  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(HOLD_CYCLES);
    localparam logic [2:0]        BLANK     = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        FILTRANDO   = 2'd1,
        TOCANDO     = 2'd2,
        SUSTENTANDO = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [7:0]        sync1, sync2;
    logic [6:0]        tk;
    logic              sk;
    logic [2:0]        cand, cand_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [HOLD_W-1:0] hold, hold_n;
    logic              from_hold, from_hold_n;
    logic [2:0]        notas_n;
    logic              tom_n, valida_n, nova_n;

    assign tk = sync2[6:0];
    assign sk = sync2[7];

    // Do (bit 0) has the highest priority.
    function automatic logic [2:0] lowest_key(input logic [6:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Mi and Si have no sharp.
    function automatic logic legal_sharp(input logic [2:0] n, input logic s);
        return s && (n != 3'd2) && (n != 3'd6);
    endfunction

    // State, counters, synchroniser and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= OCIOSO;
            sync1       <= 8'd0;
            sync2       <= 8'd0;
            cand        <= 3'd0;
            cnt         <= '0;
            hold        <= '0;
            from_hold   <= 1'b0;
            NOTAS       <= BLANK;
            TOM         <= 1'b0;
            NOTA_VALIDA <= 1'b0;
            NOVA_NOTA   <= 1'b0;
        end else begin
            state       <= state_n;
            sync1       <= {SUSTENIDO, TECLAS};
            sync2       <= sync1;
            cand        <= cand_n;
            cnt         <= cnt_n;
            hold        <= hold_n;
            from_hold   <= from_hold_n;
            NOTAS       <= notas_n;
            TOM         <= tom_n;
            NOTA_VALIDA <= valida_n;
            NOVA_NOTA   <= nova_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        cand_n      = cand;
        cnt_n       = cnt;
        hold_n      = hold;
        from_hold_n = from_hold;
        notas_n     = NOTAS;
        tom_n       = TOM;
        valida_n    = NOTA_VALIDA;
        nova_n      = 1'b0;

        case (state)
            OCIOSO: begin
                if (|tk) begin
                    cand_n      = lowest_key(tk);
                    cnt_n       = CNT_W'(1);
                    from_hold_n = 1'b0;
                    state_n     = FILTRANDO;
                end
            end
            FILTRANDO: begin
                if (tk[cand]) begin
                    if (cnt < CNT_TERM) cnt_n = cnt + CNT_W'(1);
                    if (cnt >= CNT_TERM - CNT_W'(1)) begin
                        notas_n  = cand;
                        tom_n    = legal_sharp(cand, sk);
                        valida_n = 1'b1;
                        nova_n   = 1'b1;
                        state_n  = TOCANDO;
                    end
                end else begin
                    // Bounce: go back without touching the displayed note.
                    state_n = from_hold ? SUSTENTANDO : OCIOSO;
                end
            end
            TOCANDO: begin
                tom_n = legal_sharp(cand, sk);
                if (!tk[cand]) begin
                    hold_n  = HOLD_W'(1);
                    state_n = SUSTENTANDO;
                    if (HOLD_TERM <= HOLD_W'(1)) begin
                        notas_n  = BLANK;
                        tom_n    = 1'b0;
                        valida_n = 1'b0;
                        state_n  = OCIOSO;
                    end
                end
            end
            SUSTENTANDO: begin
                if (|tk) begin
                    cand_n      = lowest_key(tk);
                    cnt_n       = CNT_W'(1);
                    from_hold_n = 1'b1;
                    state_n     = FILTRANDO;
                end else begin
                    if (hold < HOLD_TERM) hold_n = hold + HOLD_W'(1);
                    if (hold >= HOLD_TERM - HOLD_W'(1)) begin
                        notas_n  = BLANK;
                        tom_n    = 1'b0;
                        valida_n = 1'b0;
                        state_n  = OCIOSO;
                    end
                end
            end
            default: state_n = OCIOSO;
        endcase
    end

endmodule
